// File: rtl/cpu_core_ctrl.sv
// rtl/cpu_core_ctrl.sv - SAP-style CPU sequencer: ALU, program counter, micro-cycle counter, control decoder
// Optional macro CPU_CORE_JEZ_EN enables the JEZ conditional jump on opcode 0x7.
module cpu_core_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] bus_in,
  input  logic [7:0] rega,
  input  logic [7:0] regb,
  input  logic [3:0] opcode,
  input  logic       cin,
  output logic [7:0] pc,
  output logic [7:0] alu_out,
  output logic       cout,
  output logic       eq_zero,
  output logic [3:0] cycle,
  output logic [3:0] state,
  output logic       c_ai,
  output logic       c_ao,
  output logic       c_bi,
  output logic       c_ci,
  output logic       c_co,
  output logic       c_eo,
  output logic       c_ii,
  output logic       c_j,
  output logic       c_mi,
  output logic       c_oi,
  output logic       c_ro,
  output logic       c_ri,
  output logic       c_sub,
  output logic       halt
);

  typedef enum logic [3:0] {
    S_NEXT       = 4'd0,
    S_FETCH_PC   = 4'd1,
    S_FETCH_INST = 4'd2,
    S_LOAD_ADDR  = 4'd3,
    S_RAM_A      = 4'd4,
    S_RAM_B      = 4'd5,
    S_ADD        = 4'd6,
    S_SUB        = 4'd7,
    S_STORE_A    = 4'd8,
    S_OUT_A      = 4'd9,
    S_JUMP       = 4'd10,
    S_SKIP_JUMP  = 4'd11,
    S_HALT       = 4'd12
  } state_t;

  state_t     cur_state;
  logic [8:0] sum;
  logic [7:0] operand_b;
  logic       carry_in;

  assign eq_zero = (rega == 8'h00);
  assign state   = cur_state;

  // Micro-state is a pure function of opcode and cycle; the cycle counter is the only state register.
  always_comb begin
    cur_state = S_NEXT;
    case (cycle)
      4'd0: cur_state = S_FETCH_PC;
      4'd1: cur_state = S_FETCH_INST;
      default: begin
        case (opcode)
          4'h1: case (cycle)
                  4'd2: cur_state = S_FETCH_PC;
                  4'd3: cur_state = S_LOAD_ADDR;
                  4'd4: cur_state = S_RAM_A;
                  default: cur_state = S_NEXT;
                endcase
          4'h2, 4'h3: case (cycle)
                  4'd2: cur_state = S_FETCH_PC;
                  4'd3: cur_state = S_LOAD_ADDR;
                  4'd4: cur_state = S_RAM_B;
                  4'd5: cur_state = (opcode == 4'h3) ? S_SUB : S_ADD;
                  default: cur_state = S_NEXT;
                endcase
          4'h4: case (cycle)
                  4'd2: cur_state = S_FETCH_PC;
                  4'd3: cur_state = S_LOAD_ADDR;
                  4'd4: cur_state = S_STORE_A;
                  default: cur_state = S_NEXT;
                endcase
          4'h5: cur_state = (cycle == 4'd2) ? S_OUT_A : S_NEXT;
          4'h6: case (cycle)
                  4'd2: cur_state = S_FETCH_PC;
                  4'd3: cur_state = S_JUMP;
                  default: cur_state = S_NEXT;
                endcase
`ifdef CPU_CORE_JEZ_EN
          4'h7: case (cycle)
                  4'd2: cur_state = S_FETCH_PC;
                  4'd3: cur_state = eq_zero ? S_JUMP : S_SKIP_JUMP;
                  default: cur_state = S_NEXT;
                endcase
`endif
          4'hF: cur_state = S_HALT;
          default: cur_state = S_NEXT;
        endcase
      end
    endcase
  end

  // Strobes are held low during reset so nothing outside captures in the reset cycle.
  always_comb begin
    c_ai  = 1'b0;
    c_ao  = 1'b0;
    c_bi  = 1'b0;
    c_ci  = 1'b0;
    c_co  = 1'b0;
    c_eo  = 1'b0;
    c_ii  = 1'b0;
    c_j   = 1'b0;
    c_mi  = 1'b0;
    c_oi  = 1'b0;
    c_ro  = 1'b0;
    c_ri  = 1'b0;
    c_sub = 1'b0;
    halt  = 1'b0;
    if (!reset) begin
      c_ai  = (cur_state == S_RAM_A) || (cur_state == S_ADD) || (cur_state == S_SUB);
      c_ao  = (cur_state == S_OUT_A) || (cur_state == S_STORE_A);
      c_bi  = (cur_state == S_RAM_B);
      c_ci  = (cur_state == S_FETCH_INST) || (cur_state == S_JUMP) ||
              (cur_state == S_SKIP_JUMP) || (cur_state == S_LOAD_ADDR);
      c_co  = (cur_state == S_FETCH_PC);
      c_eo  = (cur_state == S_ADD) || (cur_state == S_SUB);
      c_ii  = (cur_state == S_FETCH_INST);
      c_j   = (cur_state == S_JUMP);
      c_mi  = (cur_state == S_FETCH_PC) || (cur_state == S_LOAD_ADDR);
      c_oi  = (cur_state == S_OUT_A);
      c_ro  = (cur_state == S_FETCH_INST) || (cur_state == S_JUMP) || (cur_state == S_RAM_A) ||
              (cur_state == S_RAM_B) || (cur_state == S_LOAD_ADDR);
      c_ri  = (cur_state == S_STORE_A);
      c_sub = (cur_state == S_SUB);
      halt  = (cur_state == S_HALT);
    end
  end

  // Subtract is two's complement: invert B and force the carry-in, so cout=1 means no borrow.
  assign operand_b = c_sub ? ~regb : regb;
  assign carry_in  = c_sub ? 1'b1 : cin;
  assign sum       = {1'b0, rega} + {1'b0, operand_b} + {8'h00, carry_in};
  assign alu_out   = sum[7:0];
  assign cout      = sum[8];

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= 8'h00;
    end else if (c_ci) begin
      pc <= c_j ? bus_in : pc + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || (cur_state == S_NEXT)) begin
      cycle <= 4'd0;
    end else if (cur_state != S_HALT) begin
      cycle <= cycle + 4'd1;
    end
  end

endmodule

// File: tb/tb_cpu_core_ctrl.sv
// tb/tb_cpu_core_ctrl.sv - directed self-checking bench for cpu_core_ctrl
module tb_cpu_core_ctrl;

  logic       clk;
  logic       reset;
  logic [7:0] bus_in;
  logic [7:0] rega;
  logic [7:0] regb;
  logic [3:0] opcode;
  logic       cin;
  logic [7:0] pc;
  logic [7:0] alu_out;
  logic       cout;
  logic       eq_zero;
  logic [3:0] cycle;
  logic [3:0] state;
  logic       c_ai, c_ao, c_bi, c_ci, c_co, c_eo, c_ii, c_j, c_mi, c_oi, c_ro, c_ri, c_sub;
  logic       halt;
  logic [13:0] strb;

  int checks = 0;
  int errors = 0;

  // Order: c_ai c_ao c_bi c_ci c_co c_eo c_ii c_j c_mi c_oi c_ro c_ri c_sub halt
  localparam logic [13:0] ST_NONE     = 14'b00000000000000;
  localparam logic [13:0] ST_FETCH_PC = 14'b00001000100000;
  localparam logic [13:0] ST_JUMP     = 14'b00010001001000;
  localparam logic [13:0] ST_SUB      = 14'b10000100000010;
  localparam logic [13:0] ST_OUT_A    = 14'b01000000010000;
  localparam logic [13:0] ST_HALT     = 14'b00000000000001;

  assign strb = {c_ai, c_ao, c_bi, c_ci, c_co, c_eo, c_ii, c_j, c_mi, c_oi, c_ro, c_ri, c_sub, halt};

  cpu_core_ctrl dut (
    .clk(clk), .reset(reset), .bus_in(bus_in), .rega(rega), .regb(regb),
    .opcode(opcode), .cin(cin), .pc(pc), .alu_out(alu_out), .cout(cout),
    .eq_zero(eq_zero), .cycle(cycle), .state(state),
    .c_ai(c_ai), .c_ao(c_ao), .c_bi(c_bi), .c_ci(c_ci), .c_co(c_co), .c_eo(c_eo),
    .c_ii(c_ii), .c_j(c_j), .c_mi(c_mi), .c_oi(c_oi), .c_ro(c_ro), .c_ri(c_ri),
    .c_sub(c_sub), .halt(halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clk1();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    opcode = 4'h2;
    repeat (4) clk1();
    reset = 1'b1;
    #1;
    checks++; if (strb !== ST_NONE) begin errors++; $display("FAIL reset_mask got %b exp %b", strb, ST_NONE); end
    clk1();
    clk1();
    checks++; if (pc !== 8'h00) begin errors++; $display("FAIL reset_pc got %0h exp 0", pc); end
    checks++; if (cycle !== 4'd0) begin errors++; $display("FAIL reset_cycle got %0d exp 0", cycle); end
    checks++; if (strb !== ST_NONE) begin errors++; $display("FAIL reset_strb got %b exp %b", strb, ST_NONE); end
    checks++; if (state !== 4'd1) begin errors++; $display("FAIL reset_state got %0d exp 1", state); end
    reset = 1'b0;
    #1;
    checks++; if (strb !== ST_FETCH_PC) begin errors++; $display("FAIL reset_release got %b exp %b", strb, ST_FETCH_PC); end
  endtask

  task automatic test_lda();
    logic [3:0] exp_state [6] = '{4'd1, 4'd2, 4'd1, 4'd3, 4'd4, 4'd0};
    logic [7:0] exp_pc    [6] = '{8'h00, 8'h00, 8'h01, 8'h01, 8'h02, 8'h02};
    do_reset();
    opcode = 4'h1;
    #1;
    for (int i = 0; i < 6; i++) begin
      checks++; if (state !== exp_state[i]) begin errors++; $display("FAIL lda_state[%0d] got %0d exp %0d", i, state, exp_state[i]); end
      checks++; if (pc !== exp_pc[i]) begin errors++; $display("FAIL lda_pc[%0d] got %0h exp %0h", i, pc, exp_pc[i]); end
      clk1();
    end
    checks++; if (cycle !== 4'd0) begin errors++; $display("FAIL lda_end_cycle got %0d exp 0", cycle); end
    checks++; if (pc !== 8'h02) begin errors++; $display("FAIL lda_end_pc got %0h exp 2", pc); end
  endtask

  task automatic test_alu();
    do_reset();
    opcode = 4'h3; rega = 8'h05; regb = 8'h03; cin = 1'b1;
    repeat (5) clk1();
    checks++; if (state !== 4'd7) begin errors++; $display("FAIL sub_state got %0d exp 7", state); end
    checks++; if (strb !== ST_SUB) begin errors++; $display("FAIL sub_strb got %b exp %b", strb, ST_SUB); end
    checks++; if (alu_out !== 8'h02) begin errors++; $display("FAIL sub_out got %0h exp 02", alu_out); end
    checks++; if (cout !== 1'b1) begin errors++; $display("FAIL sub_cout got %0b exp 1", cout); end
    rega = 8'h03; regb = 8'h05;
    #1;
    checks++; if (alu_out !== 8'hFE) begin errors++; $display("FAIL sub_borrow_out got %0h exp fe", alu_out); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL sub_borrow_cout got %0b exp 0", cout); end

    do_reset();
    opcode = 4'h2; rega = 8'hFF; regb = 8'h01; cin = 1'b0;
    repeat (5) clk1();
    checks++; if (state !== 4'd6) begin errors++; $display("FAIL add_state got %0d exp 6", state); end
    checks++; if (alu_out !== 8'h00) begin errors++; $display("FAIL add_out got %0h exp 00", alu_out); end
    checks++; if (cout !== 1'b1) begin errors++; $display("FAIL add_cout got %0b exp 1", cout); end
    rega = 8'h10; regb = 8'h20; cin = 1'b1;
    #1;
    checks++; if (alu_out !== 8'h31) begin errors++; $display("FAIL add_cin_out got %0h exp 31", alu_out); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL add_cin_cout got %0b exp 0", cout); end
    rega = 8'h00;
    #1;
    checks++; if (eq_zero !== 1'b1) begin errors++; $display("FAIL eq_zero_set got %0b exp 1", eq_zero); end
    rega = 8'h01;
    #1;
    checks++; if (eq_zero !== 1'b0) begin errors++; $display("FAIL eq_zero_clr got %0b exp 0", eq_zero); end
    clk1();
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL add_next got %0d exp 0", state); end
    clk1();
    checks++; if (cycle !== 4'd0) begin errors++; $display("FAIL add_len got %0d exp 0", cycle); end
    cin = 1'b0;
  endtask

  task automatic test_jmp();
    do_reset();
    opcode = 4'h6;
    repeat (3) clk1();
    bus_in = 8'h42;
    #1;
    checks++; if (state !== 4'd10) begin errors++; $display("FAIL jmp_state got %0d exp 10", state); end
    checks++; if (strb !== ST_JUMP) begin errors++; $display("FAIL jmp_strb got %b exp %b", strb, ST_JUMP); end
    clk1();
    checks++; if (pc !== 8'h42) begin errors++; $display("FAIL jmp_pc got %0h exp 42", pc); end
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL jmp_next got %0d exp 0", state); end

    do_reset();
    repeat (3) clk1();
    bus_in = 8'hFF;
    clk1();
    clk1();
    clk1();
    checks++; if (pc !== 8'hFF) begin errors++; $display("FAIL wrap_pre got %0h exp ff", pc); end
    checks++; if (state !== 4'd2) begin errors++; $display("FAIL wrap_state got %0d exp 2", state); end
    clk1();
    checks++; if (pc !== 8'h00) begin errors++; $display("FAIL wrap_pc got %0h exp 00", pc); end
  endtask

  task automatic test_jez();
`ifdef CPU_CORE_JEZ_EN
    do_reset();
    opcode = 4'h7; rega = 8'h00;
    repeat (3) clk1();
    bus_in = 8'h33;
    #1;
    checks++; if (state !== 4'd10) begin errors++; $display("FAIL jez_take_state got %0d exp 10", state); end
    clk1();
    checks++; if (pc !== 8'h33) begin errors++; $display("FAIL jez_take_pc got %0h exp 33", pc); end
    do_reset();
    rega = 8'h01;
    repeat (3) clk1();
    checks++; if (state !== 4'd11) begin errors++; $display("FAIL jez_skip_state got %0d exp 11", state); end
    clk1();
    checks++; if (pc !== 8'h02) begin errors++; $display("FAIL jez_skip_pc got %0h exp 02", pc); end
`else
    do_reset();
    opcode = 4'h7; rega = 8'h00;
    repeat (2) clk1();
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL jez_off_state got %0d exp 0", state); end
    checks++; if (strb !== ST_NONE) begin errors++; $display("FAIL jez_off_strb got %b exp %b", strb, ST_NONE); end
    clk1();
    checks++; if (cycle !== 4'd0) begin errors++; $display("FAIL jez_off_cycle got %0d exp 0", cycle); end
`endif
  endtask

  task automatic test_out();
    do_reset();
    opcode = 4'h5;
    repeat (2) clk1();
    checks++; if (state !== 4'd9) begin errors++; $display("FAIL out_state got %0d exp 9", state); end
    checks++; if (strb !== ST_OUT_A) begin errors++; $display("FAIL out_strb got %b exp %b", strb, ST_OUT_A); end
    clk1();
    clk1();
    checks++; if (cycle !== 4'd0) begin errors++; $display("FAIL out_len got %0d exp 0", cycle); end
    checks++; if (pc !== 8'h01) begin errors++; $display("FAIL out_pc got %0h exp 01", pc); end
  endtask

  task automatic test_hlt();
    int bad;
    do_reset();
    opcode = 4'hF;
    repeat (2) clk1();
    checks++; if (strb !== ST_HALT) begin errors++; $display("FAIL hlt_strb got %b exp %b", strb, ST_HALT); end
    checks++; if (state !== 4'd12) begin errors++; $display("FAIL hlt_state got %0d exp 12", state); end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      clk1();
      checks++;
      if (cycle !== 4'd2 || pc !== 8'h01) begin
        errors++;
        $display("FAIL hlt_freeze[%0d] got cycle %0d pc %0h exp cycle 2 pc 01", i, cycle, pc);
      end
    end
    reset = 1'b1;
    #1;
    checks++; if (halt !== 1'b0) begin errors++; $display("FAIL hlt_reset_mask got %0b exp 0", halt); end
    clk1();
    reset = 1'b0;
    #1;
    checks++; if (state !== 4'd1) begin errors++; $display("FAIL hlt_exit_state got %0d exp 1", state); end
    checks++; if (pc !== 8'h00) begin errors++; $display("FAIL hlt_exit_pc got %0h exp 00", pc); end
  endtask

  initial begin
    reset = 1'b1; bus_in = 8'h00; rega = 8'h00; regb = 8'h00; opcode = 4'h0; cin = 1'b0;
    test_reset();
    test_lda();
    test_alu();
    test_jmp();
    test_jez();
    test_out();
    test_hlt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
